uart_rx_cmd_ctrl: RTL and testbench

Frame controller that sequences the UART receiver's byte stream into register-write commands.
- Consumes the receiver's one-cycle `rcv` strobe and `last` byte.
- Parses fixed 4-byte frames: SOF, ADDR, DATA, CHK.
- On a valid frame, issues a single-cycle register write toward the board's control register bank.
- Flags checksum errors and inter-byte timeouts, then resynchronises on the next SOF.

---
 rtl/uart_rx_cmd_ctrl.sv | 70 +++++++
 tb/tb_uart_rx_cmd_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd_ctrl.sv
// uart_rx_cmd_ctrl: parses SOF/ADDR/DATA/CHK byte frames from the UART receiver into register writes.
module uart_rx_cmd_ctrl #(
  parameter logic [7:0] SOF_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CYC = 12000,
  parameter int         ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rcv,
  input  logic [7:0]        last,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              err_chk,
  output logic              err_tmo,
  output logic              busy,
  output logic [7:0]        frame_cnt
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, CHK} state_t;
  state_t        state;
  logic [7:0]    addr_q, data_q;
  logic [CW-1:0] cnt;
  logic          tmo;
  // a byte arriving in the expiry cycle takes priority over the timeout
  assign tmo  = state != IDLE && !rcv && cnt == CW'(TIMEOUT_CYC - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      cnt       <= '0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      err_chk   <= 1'b0;
      err_tmo   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      reg_we  <= 1'b0;
      err_chk <= 1'b0;
      err_tmo <= tmo;
      cnt     <= (rcv || state == IDLE || tmo) ? '0 : cnt + 1'b1;
      if (tmo) state <= IDLE;
      else if (rcv) begin
        case (state)
          IDLE: state <= (last == SOF_BYTE) ? ADDR : IDLE;
          ADDR: begin
            addr_q <= last;
            state  <= DATA;
          end
          DATA: begin
            data_q <= last;
            state  <= CHK;
          end
          CHK: begin
            state <= IDLE;
            if (last == (SOF_BYTE ^ addr_q ^ data_q)) begin
              reg_we    <= 1'b1;
              reg_addr  <= addr_q[ADDR_W-1:0];
              reg_wdata <= data_q;
              frame_cnt <= frame_cnt + 1'b1;
            end else err_chk <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// tb_uart_rx_cmd_ctrl: directed and random frames checked against a queue-based frame model.
module tb_uart_rx_cmd_ctrl;
  localparam int TMO = 50;
  localparam logic [7:0] SOF = 8'hA5;
  logic       clk = 1'b0, rstn = 1'b0, rcv = 1'b0;
  logic [7:0] last = '0;
  logic       reg_we, err_chk, err_tmo, busy;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata, frame_cnt;
  int total = 0, bad = 0, mon_tmo = 0, m_tmo = 0;
  logic [7:0] frm[$];
  logic [7:0] m_cnt = '0, m_data = '0;
  logic [3:0] m_addr = '0;

  uart_rx_cmd_ctrl #(.SOF_BYTE(SOF), .TIMEOUT_CYC(TMO), .ADDR_W(4)) dut (
    .clk(clk), .rstn(rstn), .rcv(rcv), .last(last), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .err_chk(err_chk), .err_tmo(err_tmo), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (err_tmo) mon_tmo++;
    chk("mutex", 32'(int'(reg_we) + int'(err_chk) + int'(err_tmo) <= 1), 32'd1);
  end

  task automatic send(input logic [7:0] b, input int gap);
    logic ew, ec;
    repeat (gap) @(negedge clk);
    if (frm.size() > 0 && gap + 1 > TMO) begin
      frm.delete();
      m_tmo++;
    end
    ew = 1'b0;
    ec = 1'b0;
    if (frm.size() > 0 || b == SOF) frm.push_back(b);
    if (frm.size() == 4) begin
      if (frm[3] == (frm[0] ^ frm[1] ^ frm[2])) begin
        ew = 1'b1;
        m_addr = frm[1][3:0];
        m_data = frm[2];
        m_cnt = m_cnt + 8'd1;
      end else ec = 1'b1;
      frm.delete();
    end
    rcv = 1'b1;
    last = b;
    @(negedge clk);
    rcv = 1'b0;
    #1;
    chk("reg_we", 32'(reg_we), 32'(ew));
    chk("err_chk", 32'(err_chk), 32'(ec));
    chk("err_tmo", 32'(err_tmo), 32'd0);
    chk("reg_addr", 32'(reg_addr), 32'(m_addr));
    chk("reg_wdata", 32'(reg_wdata), 32'(m_data));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    chk("busy", 32'(busy), 32'(frm.size() > 0));
    chk("tmo_count", 32'(mon_tmo), 32'(m_tmo));
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic good, input int gap);
    send(SOF, gap);
    send(a, gap);
    send(d, gap);
    send(good ? (SOF ^ a ^ d) : ~(SOF ^ a ^ d), gap);
  endtask

  task automatic do_reset;
    #2 rstn = 1'b0;
    #1;
    chk("reset_outputs", 32'({reg_we, err_chk, err_tmo, busy, reg_addr, reg_wdata, frame_cnt}), 32'd0);
    frm.delete();
    m_cnt = '0;
    m_addr = '0;
    m_data = '0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    int n;
    logic [7:0] a, d;
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] a, d;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 32'({reg_we, err_chk, err_tmo, busy, reg_addr, reg_wdata, frame_cnt}), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    frame(8'h03, 8'h5C, 1'b1, 40);
    frame(8'h03, 8'h5C, 1'b0, 3);
    send(SOF, 2);
    send(8'h01, 0);
    for (n = 1; n <= 60; n++) begin
      @(negedge clk);
      #1;
      if (err_tmo) break;
    end
    chk("tmo_latency", 32'(n), 32'd50);
    chk("tmo_busy", 32'(busy), 32'd0);
    frm.delete();
    m_tmo++;
    frame(8'h09, 8'h77, 1'b1, 1);
    foreach (frm[i]) frm.delete();
    send(8'h00, 2);
    send(8'hFF, 0);
    send(8'h12, 0);
    send(SOF, 0);
    send(8'h1F, 0);
    send(SOF, 0);
    send(8'h1F, 0);
    send(SOF, 0);
    send(8'h07, 0);
    send(8'h33, TMO - 1);
    send(SOF ^ 8'h07 ^ 8'h33, 0);
    send(SOF, 0);
    send(8'h0E, 0);
    send(8'h44, TMO);
    for (int k = 0; k < 60; k++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      if ($urandom_range(0, 4) == 0) send(8'($urandom), $urandom_range(0, 3));
      send(SOF, $urandom_range(0, 4));
      send(a, ($urandom_range(0, 5) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 4));
      send(d, ($urandom_range(0, 5) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 4));
      send(($urandom_range(0, 3) == 0) ? 8'($urandom) : (SOF ^ a ^ d), $urandom_range(0, 4));
    end
    frame(8'h05, 8'h66, 1'b1, 0);
    send(SOF, 0);
    send(8'h03, 0);
    do_reset();
    frame(8'h02, 8'h81, 1'b1, 0);
    chk("post_reset_cnt", 32'(frame_cnt), 32'd1);
    do_reset();
    for (int k = 0; k < 256; k++) frame(8'(k), 8'(k * 3), 1'b1, 0);
    chk("wrap_cnt", 32'(frame_cnt), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
